// File: rtl/cond_unit.sv
// cond_unit: evaluates condition codes against Z/N/C/V,
// stalling on in-flight flag writes with same-cycle forwarding.
module cond_unit #(
  parameter int TAG_W    = 4,
  parameter int MAX_PEND = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       flag_in,
  input  logic             flag_wen,
  input  logic [3:0]       flag_next,
  input  logic             set_issue,
  output logic             issue_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_pass,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       pend_cnt,
  output logic             pend_err
);

  localparam logic [2:0] PMAX = 3'(MAX_PEND);

  logic       cnt_zero;
  logic       cnt_one;
  logic       set_acc;
  logic       dec;
  logic       flags_clear;
  logic       accept;
  logic [3:0] eff;
  logic       z, n, c, v;
  logic       pass_d;

  assign cnt_zero    = (pend_cnt == 3'd0);
  assign cnt_one     = (pend_cnt == 3'd1);
  assign issue_ready = (pend_cnt < PMAX);
  assign set_acc     = set_issue && issue_ready;
  assign dec         = flag_wen && !cnt_zero;

  // A same-cycle set_issue holds the request back even when
  // nothing is pending: ordering stays conservative.
  assign flags_clear =
    (cnt_zero && !flag_wen && !set_issue) ||
    (cnt_one && flag_wen && !set_issue);

  assign in_ready = flags_clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign eff = flag_wen ? flag_next : flag_in;
  assign z   = eff[3];
  assign n   = eff[2];
  assign c   = eff[1];
  assign v   = eff[0];

  // Condition decode on the effective flags.
  always_comb begin
    pass_d = 1'b0;
    unique case (in_cond)
      4'd0:  pass_d = z;
      4'd1:  pass_d = !z;
      4'd2:  pass_d = c;
      4'd3:  pass_d = !c;
      4'd4:  pass_d = n;
      4'd5:  pass_d = !n;
      4'd6:  pass_d = v;
      4'd7:  pass_d = !v;
      4'd8:  pass_d = c && !z;
      4'd9:  pass_d = !c || z;
      4'd10: pass_d = (n == v);
      4'd11: pass_d = (n != v);
      4'd12: pass_d = !z && (n == v);
      4'd13: pass_d = z || (n != v);
      4'd14: pass_d = 1'b1;
      4'd15: pass_d = 1'b0;
    endcase
  end

  // Outstanding flag-write counter and sticky misuse flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_cnt <= 3'd0;
      pend_err <= 1'b0;
    end else begin
      if (set_acc && !dec)
        pend_cnt <= pend_cnt + 3'd1;
      else if (dec && !set_acc)
        pend_cnt <= pend_cnt - 3'd1;
      if ((flag_wen && cnt_zero) ||
          (set_issue && !issue_ready))
        pend_err <= 1'b1;
    end
  end

  // Single-entry result register with hold on back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pass  <= 1'b0;
      out_tag   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pass  <= pass_d;
      out_tag   <= in_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
